// File: rtl/dm_request_controller.sv
// MEM-stage data memory request controller: aligns load/store requests, drives the
// valid/ready request handshake, waits for read responses and holds the returned word.
module dm_request_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [1:0]  i_size,
  input  logic [63:0] i_addr,
  input  logic [63:0] i_wdata,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_misaligned,
  output logic        o_bus_error,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic        o_mem_we,
  output logic [63:0] o_mem_addr,
  output logic [7:0]  o_mem_strb,
  output logic [63:0] o_mem_wdata,
  input  logic        i_mem_rsp_valid,
  input  logic [63:0] i_mem_rsp_data,
  output logic [63:0] o_dm_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] SZ_B  = 2'b00;
  localparam logic [1:0] SZ_HW = 2'b01;
  localparam logic [1:0] SZ_W  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kill_q, kill_d;

  logic             done_d, misaligned_d, bus_error_d;
  logic             req_valid_d, we_d;
  logic [63:0]      addr_d, wdata_d, dm_data_d;
  logic [7:0]       strb_d;
  logic             stall_c;

  logic [2:0]       lane;
  logic             access;
  logic             misaligned;
  logic [7:0]       strb;
  logic [63:0]      wdata_shifted;
  logic             kill_now;

  // Request decode: alignment check, byte strobes and lane-shifted store data
  always_comb begin
    lane          = i_addr[2:0];
    access        = i_valid & (i_mem_rd | i_mem_wr) & ~i_flush;
    wdata_shifted = i_wdata << {lane, 3'b000};
    case (i_size)
      SZ_B: begin
        misaligned = 1'b0;
        strb       = 8'h01 << lane;
      end
      SZ_HW: begin
        misaligned = lane[0];
        strb       = 8'h03 << lane;
      end
      SZ_W: begin
        misaligned = |lane[1:0];
        strb       = 8'h0F << lane;
      end
      default: begin
        misaligned = |lane;
        strb       = 8'hFF;
      end
    endcase
  end

  // A flush seen in the same cycle as completion must also suppress the pulses
  assign kill_now = kill_q | i_flush;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    kill_d       = kill_q;
    done_d       = 1'b0;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;
    req_valid_d  = o_mem_req_valid;
    we_d         = o_mem_we;
    addr_d       = o_mem_addr;
    strb_d       = o_mem_strb;
    wdata_d      = o_mem_wdata;
    dm_data_d    = o_dm_data;
    stall_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (access) begin
          stall_c = 1'b1;
          if (misaligned) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            misaligned_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            we_d        = i_mem_wr;
            addr_d      = {i_addr[63:3], 3'b000};
            strb_d      = strb;
            wdata_d     = wdata_shifted;
          end
        end
      end

      S_REQ: begin
        stall_c = 1'b1;
        if (i_flush) kill_d = 1'b1;
        if (i_mem_req_ready) begin
          req_valid_d = 1'b0;
          if (o_mem_we) begin
            state_d = S_DONE;
            done_d  = ~kill_now;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end

      S_WAIT: begin
        stall_c = 1'b1;
        if (i_flush) kill_d = 1'b1;
        if (i_mem_rsp_valid) begin
          dm_data_d = i_mem_rsp_data;
          state_d   = S_DONE;
          done_d    = ~kill_now;
        end else if (cnt_q == CNT_LAST) begin
          dm_data_d   = '0;
          state_d     = S_DONE;
          done_d      = ~kill_now;
          bus_error_d = ~kill_now;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  // Stall is combinational so the pipeline freezes in the cycle the access is seen
  assign o_stall = stall_c & ~i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      kill_q          <= 1'b0;
      o_done          <= 1'b0;
      o_misaligned    <= 1'b0;
      o_bus_error     <= 1'b0;
      o_mem_req_valid <= 1'b0;
      o_mem_we        <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_strb      <= '0;
      o_mem_wdata     <= '0;
      o_dm_data       <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      kill_q          <= kill_d;
      o_done          <= done_d;
      o_misaligned    <= misaligned_d;
      o_bus_error     <= bus_error_d;
      o_mem_req_valid <= req_valid_d;
      o_mem_we        <= we_d;
      o_mem_addr      <= addr_d;
      o_mem_strb      <= strb_d;
      o_mem_wdata     <= wdata_d;
      o_dm_data       <= dm_data_d;
    end
  end

endmodule

// File: doc/dm_request_controller.md
Name: dm_request_controller

Overview:
- MEM-stage front end for the data memory. Turns a load/store from the EX/MEM register into a doubleword-aligned memory request with byte strobes and lane-shifted write data.
- Drives a valid/ready request handshake and waits a variable latency for read responses. Stalls the pipeline while an access is in flight.
- Holds the returned 64-bit word on o_dm_data, where the downstream load controller extracts byte/halfword/word/doubleword lanes.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT_RSP before a bus error; legal range 1..(2^CNT_W)-1
CNT_W, 8, width of timeout counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_valid  in  1  MEM-stage instruction valid
i_mem_rd  in  1  load request
i_mem_wr  in  1  store request (i_mem_rd and i_mem_wr never both 1)
i_size  in  2  access size: 00=`B, 01=`HW, 10=`W, 11=`DW
i_addr  in  64  byte address
i_wdata  in  64  store data, right-aligned
i_flush  in  1  kill current MEM-stage instruction
o_stall  out  1  hold upstream pipeline
o_done  out  1  one-cycle pulse, access complete
o_misaligned  out  1  one-cycle pulse, misaligned access rejected
o_bus_error  out  1  one-cycle pulse, response timeout
o_mem_req_valid  out  1  request valid to data memory
i_mem_req_ready  in  1  memory accepts request
o_mem_we  out  1  1=write, 0=read
o_mem_addr  out  64  {addr[63:3],3'b000}
o_mem_strb  out  8  byte enables
o_mem_wdata  out  64  lane-shifted write data
i_mem_rsp_valid  in  1  read response valid
i_mem_rsp_data  in  64  read response data
o_dm_data  out  64  captured read word to load controller

Behaviour:
- Reset (async, i_rst=1): state=IDLE. Counter=0, kill flag=0. All outputs 0, including o_dm_data=64'h0.
- Alignment rule: addr[0]=0 for HW, addr[1:0]=0 for W, addr[2:0]=0 for DW. B is always aligned.
- Strobes: B=8'h01<<a; HW=8'h03<<a; W=8'h0F<<a; DW=8'hFF, where a=addr[2:0]. Write data: i_wdata<<(8*a), truncated to 64 bits.
- FSM states IDLE, REQ, WAIT_RSP, DONE.
- IDLE, access = i_valid & (i_mem_rd|i_mem_wr) & !i_flush:
  - Aligned: latch addr/strb/wdata/we. Next-cycle o_mem_req_valid=1, go to REQ. o_stall=1 combinationally in this cycle.
  - Misaligned: no memory request. Registered o_misaligned=1 and o_done=1 next cycle (state DONE). o_stall=1 in this cycle.
  - No access or i_flush=1: stay in IDLE, o_stall=0.
- REQ: o_mem_req_valid held high with stable addr/strb/wdata/we until i_mem_req_ready=1 (handshake in same cycle). Then o_mem_req_valid=0 next cycle. A write goes to DONE; a read goes to WAIT_RSP with counter cleared. o_stall=1.
- WAIT_RSP: counter increments each cycle. o_stall=1.
  - i_mem_rsp_valid=1: o_dm_data<=i_mem_rsp_data, go to DONE.
  - Counter reaches TIMEOUT_CYCLES without a response: o_dm_data<=0, o_bus_error pulses in DONE, go to DONE.
  - Response and timeout in the same cycle: the response wins.
  - Responses outside WAIT_RSP are ignored.
- DONE: o_stall=0, o_done=1 for exactly one cycle (0 if kill flag set), then IDLE. i_valid is ignored in DONE because it is still the old instruction.
- o_dm_data holds its value until the next captured response or reset.
- Flush in REQ/WAIT_RSP: sets kill flag. The transaction still completes on the bus, and a store is still performed. o_done, o_misaligned and o_bus_error are suppressed in DONE. Kill flag clears on entry to IDLE.
- Latency with memory ready and 1-cycle response: read done at IDLE+3 (IDLE→REQ→WAIT→DONE); write done at IDLE+2.
- Reset mid-transaction: immediate return to IDLE, outputs 0; any outstanding response is dropped.

Test Plan:
- Load DW at addr 0x1000, ready=1, rsp_valid one cycle after accept with data 0x1122334455667788 → o_mem_addr=0x1000, strb=8'hFF, o_done at cycle 3, o_dm_data=0x1122334455667788, o_stall high cycles 0–2.
- Store B at addr 0x2005 with wdata=0xAB, ready delayed 4 cycles → valid/addr=0x2000/strb=8'h20/wdata=0x0000AB0000000000 stable until accept, then o_done pulse.
- Load W at addr 0x3002 → no o_mem_req_valid, o_misaligned=1 and o_done=1 one cycle later; HW at 0x3002 is accepted with strb=8'h0C.
- Load with TIMEOUT_CYCLES=4 and no response → o_bus_error pulse after 4 WAIT cycles, o_dm_data=0, return to IDLE.
- i_flush asserted in WAIT_RSP, response arrives 2 cycles later → data captured, o_done=0, back to IDLE; a flush in IDLE produces no request.
- i_rst asserted in WAIT_RSP → all outputs 0 asynchronously; a late rsp_valid after reset release is ignored.
